// File: rtl/vga_text_pkg.sv
// Shared widths and the VGA timing bundle for the text overlay pipeline.
package vga_text_pkg;
   localparam int GLYPH_W     = 16;
   localparam int GLYPH_H     = 16;
   localparam int CHAR_CODE_W = 7;
   localparam int CHAR_YX_W   = 10;
   localparam int RGB_W       = 12;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } vga_timing_t;
endpackage

// File: rtl/draw_text_char_32x32_if.sv
// Pixel stream in/out plus the character-ROM and font-ROM links of the text overlay.
interface draw_text_char_32x32_if;
   import vga_text_pkg::*;

   logic [10:0]            hcount_in;
   logic [10:0]            vcount_in;
   logic                   hsync_in;
   logic                   vsync_in;
   logic                   hblnk_in;
   logic                   vblnk_in;
   logic [RGB_W-1:0]       rgb_in;
   logic [CHAR_CODE_W-1:0] char_code;
   logic [15:0]            font_row;
   logic [CHAR_YX_W-1:0]   char_yx;
   logic [3:0]             char_line;
   logic [10:0]            hcount_out;
   logic [10:0]            vcount_out;
   logic                   hsync_out;
   logic                   vsync_out;
   logic                   hblnk_out;
   logic                   vblnk_out;
   logic [RGB_W-1:0]       rgb_out;

   modport master (
      output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      output char_code, font_row,
      input  char_yx, char_line,
      input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
   );

   modport slave (
      input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
      input  char_code, font_row,
      output char_yx, char_line,
      output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out
   );
endinterface

// File: rtl/vga_timing_delay.sv
// N-stage delay line for the VGA timing bundle and colour; latency N clk.
// No backpressure: shifts one pixel per clk unconditionally.
module vga_timing_delay
   import vga_text_pkg::*;
#(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  vga_timing_t      timing_in,
   input  logic [RGB_W-1:0] rgb_in,
   output vga_timing_t      timing_out,
   output logic [RGB_W-1:0] rgb_out
);
   vga_timing_t      timing_q [N];
   logic [RGB_W-1:0] rgb_q    [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            timing_q[i] <= '0;
            rgb_q[i]    <= '0;
         end
      end else begin
         timing_q[0] <= timing_in;
         rgb_q[0]    <= rgb_in;
         for (int i = 1; i < N; i++) begin
            timing_q[i] <= timing_q[i-1];
            rgb_q[i]    <= rgb_q[i-1];
         end
      end
   end

   assign timing_out = timing_q[N-1];
   assign rgb_out    = rgb_q[N-1];
endmodule

// File: rtl/draw_text_char_32x32.sv
// Overlays a 32x32-cell text grid (16x16 glyphs) on the pixel stream; 4 clk latency.
// No backpressure: one pixel per clk, ROM lookups are fixed-latency.
module draw_text_char_32x32
   import vga_text_pkg::*;
#(
   parameter int unsigned      X_POS     = 256,
   parameter int unsigned      Y_POS     = 64,
   parameter int unsigned      TEXT_COLS = 32,
   parameter int unsigned      TEXT_ROWS = 20,
   parameter logic [RGB_W-1:0] FG_COLOR  = 12'hFFF
) (
   input logic                   clk,
   input logic                   rst_n,
   draw_text_char_32x32_if.slave bus
);
   localparam logic [10:0] X_LO = 11'(X_POS);
   localparam logic [10:0] X_HI = 11'(X_POS + TEXT_COLS * GLYPH_W);
   localparam logic [10:0] Y_LO = 11'(Y_POS);
   localparam logic [10:0] Y_HI = 11'(Y_POS + TEXT_ROWS * GLYPH_H);

   logic [8:0]       rel_x;
   logic [8:0]       rel_y;
   logic             in_region;
   vga_timing_t      timing_in;
   vga_timing_t      timing_s3;
   logic [RGB_W-1:0] rgb_s3;
   logic [3:0]       line_s1;
   logic [3:0]       col_s1, col_s2, col_s3;
   logic             in_s1, in_s2, in_s3;
   logic [3:0]       bit_idx;
   logic             pix;

   assign rel_x     = 9'(bus.hcount_in - X_LO);
   assign rel_y     = 9'(bus.vcount_in - Y_LO);
   // Lower bounds are explicit so pixels left of / above the area never alias in via wrap.
   assign in_region = (bus.hcount_in >= X_LO) && (bus.hcount_in < X_HI) &&
                      (bus.vcount_in >= Y_LO) && (bus.vcount_in < Y_HI);

   assign timing_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                        hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                        hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in};

   vga_timing_delay #(.N(3)) u_timing_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .timing_in  (timing_in),
      .rgb_in     (bus.rgb_in),
      .timing_out (timing_s3),
      .rgb_out    (rgb_s3)
   );

   // Font row MSB is the leftmost pixel.
   assign bit_idx = 4'd15 - col_s3;
   assign pix     = bus.font_row[bit_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.char_yx    <= '0;
         bus.char_line  <= '0;
         line_s1        <= '0;
         col_s1         <= '0;
         col_s2         <= '0;
         col_s3         <= '0;
         in_s1          <= 1'b0;
         in_s2          <= 1'b0;
         in_s3          <= 1'b0;
         bus.hcount_out <= '0;
         bus.vcount_out <= '0;
         bus.hsync_out  <= 1'b0;
         bus.vsync_out  <= 1'b0;
         bus.hblnk_out  <= 1'b0;
         bus.vblnk_out  <= 1'b0;
         bus.rgb_out    <= '0;
      end else begin
         bus.char_yx   <= in_region ? {rel_y[8:4], rel_x[8:4]} : '0;
         line_s1       <= rel_y[3:0];
         col_s1        <= rel_x[3:0];
         in_s1         <= in_region;
         // char_line lands with char_code so {char_code, char_line} is a coherent font address.
         bus.char_line <= line_s1;
         col_s2        <= col_s1;
         in_s2         <= in_s1;
         col_s3        <= col_s2;
         in_s3         <= in_s2;

         bus.hcount_out <= timing_s3.hcount;
         bus.vcount_out <= timing_s3.vcount;
         bus.hsync_out  <= timing_s3.hsync;
         bus.vsync_out  <= timing_s3.vsync;
         bus.hblnk_out  <= timing_s3.hblnk;
         bus.vblnk_out  <= timing_s3.vblnk;
         if (timing_s3.hblnk || timing_s3.vblnk)
            bus.rgb_out <= '0;
         else if (in_s3 && pix)
            bus.rgb_out <= FG_COLOR;
         else
            bus.rgb_out <= rgb_s3;
      end
   end
endmodule

// File: tb/tb_draw_text_char_32x32.sv
// Random and directed pixel stream against a per-pixel reference model of the text overlay.
module tb_draw_text_char_32x32;
   localparam int          X_POS     = 256;
   localparam int          Y_POS     = 64;
   localparam int          TEXT_COLS = 32;
   localparam int          TEXT_ROWS = 20;
   localparam logic [11:0] FG        = 12'hFFF;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync, vsync, hblnk, vblnk;
      logic [11:0] rgb;
      logic        rst;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;

   stim_t       hist     [4096];
   logic [6:0]  char_mem [1024];
   logic [15:0] font_mem [2048];

   draw_text_char_32x32_if bus ();

   draw_text_char_32x32 #(
      .X_POS(X_POS), .Y_POS(Y_POS), .TEXT_COLS(TEXT_COLS), .TEXT_ROWS(TEXT_ROWS), .FG_COLOR(FG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Registered character ROM and font ROM, one clk each.
   always @(posedge clk) begin
      bus.char_code <= char_mem[bus.char_yx];
      bus.font_row  <= font_mem[{bus.char_code, bus.char_line}];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // ---- reference model, straight from the geometry ----
   function automatic bit in_reg(stim_t s);
      int h = int'(s.hcount);
      int v = int'(s.vcount);
      return h >= X_POS && h < X_POS + TEXT_COLS * 16 && v >= Y_POS && v < Y_POS + TEXT_ROWS * 16;
   endfunction

   function automatic int cell_of(stim_t s);
      return ((int'(s.vcount) - Y_POS) / 16) * 32 + (int'(s.hcount) - X_POS) / 16;
   endfunction

   function automatic logic [9:0] m_yx(stim_t s);
      return in_reg(s) ? 10'(cell_of(s)) : 10'h000;
   endfunction

   function automatic logic [3:0] m_line(stim_t s);
      return 4'((int'(s.vcount) - Y_POS) & 15);
   endfunction

   function automatic logic [11:0] m_rgb(stim_t s);
      int col, code, row;
      if (s.hblnk || s.vblnk) return 12'h000;
      if (!in_reg(s)) return s.rgb;
      col  = (int'(s.hcount) - X_POS) % 16;
      code = int'(char_mem[cell_of(s)]);
      row  = int'(font_mem[code * 16 + int'(m_line(s))]);
      return (((row >> (15 - col)) & 1) == 1) ? FG : s.rgb;
   endfunction

   // True when the DUT has been out of reset for edges n-d..n.
   function automatic bit ok(int n, int d);
      if (!rst_n || n - d < 1) return 1'b0;
      for (int k = n - d; k <= n; k++) if (!hist[k].rst) return 1'b0;
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (edge_n >= 1) begin
         stim_t s3;
         s3 = ok(edge_n, 3) ? hist[edge_n - 3] : '0;
         chk("yx",   bus.char_yx,   ok(edge_n, 0) ? m_yx(hist[edge_n]) : 10'h000);
         chk("line", bus.char_line, ok(edge_n, 1) ? m_line(hist[edge_n - 1]) : 4'h0);
         chk("rgb",  bus.rgb_out,   ok(edge_n, 3) ? m_rgb(s3) : 12'h000);
         chk("hcnt", bus.hcount_out, s3.hcount);
         chk("vcnt", bus.vcount_out, s3.vcount);
         chk("sync", {bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out},
             {s3.hsync, s3.vsync, s3.hblnk, s3.vblnk});
      end
   end

   // ---- stimulus helpers ----
   task automatic step();
      @(posedge clk);
      edge_n++;
      hist[edge_n] = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                       hsync: bus.hsync_in, vsync: bus.vsync_in,
                       hblnk: bus.hblnk_in, vblnk: bus.vblnk_in,
                       rgb: bus.rgb_in, rst: rst_n};
      #1;
   endtask

   task automatic drive(input int h, input int v, input logic [11:0] rgb,
                        input logic hs, input logic vs, input logic hb, input logic vb);
      bus.hcount_in = 11'(h);
      bus.vcount_in = 11'(v);
      bus.rgb_in    = rgb;
      bus.hsync_in  = hs;
      bus.vsync_in  = vs;
      bus.hblnk_in  = hb;
      bus.vblnk_in  = vb;
   endtask

   task automatic drive_rand();
      drive($urandom_range(220, 800), $urandom_range(50, 400), 12'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_rgb"},  bus.rgb_out,    12'h000);
      chk({nm, "_yx"},   bus.char_yx,    10'h000);
      chk({nm, "_line"}, bus.char_line,  4'h0);
      chk({nm, "_hcnt"}, bus.hcount_out, 11'h000);
      chk({nm, "_vcnt"}, bus.vcount_out, 11'h000);
      chk({nm, "_sync"}, {bus.hsync_out, bus.vsync_out, bus.hblnk_out, bus.vblnk_out}, 4'h0);
   endtask

   task automatic yx_at(input string nm, input int h, input int v, input logic [9:0] exp);
      drive(h, v, 12'h111, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk(nm, bus.char_yx, exp);
   endtask

   task automatic px_at(input string nm, input int h, input int v, input logic [11:0] rgb,
                        input logic hs, input logic hb, input logic [11:0] exp_rgb);
      drive(h, v, rgb, hs, 1'b0, hb, 1'b0);
      step();
      drive(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      @(negedge clk);
      chk(nm, bus.rgb_out, exp_rgb);
      chk({nm, "_hs"}, bus.hsync_out, hs);
      chk({nm, "_hb"}, bus.hblnk_out, hb);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) char_mem[i] = 7'($urandom_range(1, 127));
      for (int i = 0; i < 2048; i++) font_mem[i] = 16'($urandom);
      for (int l = 0; l < 16; l++) begin
         font_mem[l]           = 16'h0000;
         font_mem[32 * 16 + l] = 16'h0000;
      end
      char_mem[0]          = 7'h20;
      char_mem[10'h043]    = 7'd117;
      font_mem[117*16 + 7] = 16'h8001;

      rst_n = 1'b0;
      drive(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 check_zero("reset");
      repeat (3) step();
      rst_n = 1'b1;

      for (int i = 0; i < 800; i++) begin
         drive_rand();
         step();
      end

      // character (3,2), glyph line 7
      drive(X_POS + 16*3 + 5, Y_POS + 16*2 + 7, 12'h321, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("addr_yx", bus.char_yx, 10'h043);
      step();
      @(negedge clk);
      chk("addr_line", bus.char_line, 4'd7);
      chk("addr_code", bus.char_code, 7'd117);

      px_at("outside",  100, 30, 12'h0A5, 1'b1, 1'b0, 12'h0A5);
      px_at("glyph_c0", X_POS + 48,      Y_POS + 39, 12'h5A5, 1'b0, 1'b0, FG);
      px_at("glyph_c1", X_POS + 48 + 1,  Y_POS + 39, 12'h5A5, 1'b0, 1'b0, 12'h5A5);
      px_at("glyph_cf", X_POS + 48 + 15, Y_POS + 39, 12'h5A5, 1'b1, 1'b0, FG);
      px_at("blank",    X_POS + 48,      Y_POS + 39, 12'h5A5, 1'b0, 1'b1, 12'h000);

      yx_at("out_yx",   100,           30,            10'h000);
      yx_at("x_last",   X_POS + 511,   Y_POS,         10'h01F);
      yx_at("x_past",   X_POS + 512,   Y_POS,         10'h000);
      yx_at("y_before", X_POS + 44,    Y_POS - 1,     10'h000);
      yx_at("x_before", X_POS - 1,     Y_POS + 20,    10'h000);
      yx_at("y_last",   X_POS,         Y_POS + 319,   10'h260);
      yx_at("y_past",   X_POS,         Y_POS + 320,   10'h000);

      for (int i = 0; i < 300; i++) begin
         drive_rand();
         step();
      end

      // asynchronous reset in the middle of a line
      rst_n = 1'b0;
      #1 check_zero("arst");
      for (int i = 0; i < 2; i++) begin
         drive_rand();
         step();
      end
      rst_n = 1'b1;

      for (int i = 0; i < 600; i++) begin
         drive_rand();
         step();
      end
      repeat (6) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/draw_text_char_32x32.md
Name: draw_text_char_32x32

Overview:
- Consumer side of the character-ROM interface: the reader that walks the 32x32 text grid.
- Sits in the VGA pixel pipeline after the background/tile drawing stages.
- From hcount/vcount it drives char_yx to the character ROM, receives char_code, and addresses the font ROM with {char_code, char_line}.
- It overlays glyph pixels on rgb_in and delays all VGA timing signals so they stay aligned with the overlaid colour.

Parameters:
- X_POS, 256, left pixel column of the text area.
- Y_POS, 64, top pixel row of the text area.
- TEXT_COLS, 32, characters per text line (max 32, 5-bit x index).
- TEXT_ROWS, 20, text lines (max 32, 5-bit y index).
- FG_COLOR, 12'hFFF, RGB444 colour of set glyph pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical pixel counter.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blanking.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  12  background colour.
- char_code  in  7  glyph code from the character ROM; registered, valid 1 clk after char_yx.
- font_row  in  16  glyph row bits from the font ROM; registered, valid 1 clk after address; MSB is the leftmost pixel.
- char_yx  out  10  {char_y[4:0], char_x[4:0]} to the character ROM.
- char_line  out  4  glyph row index for the font ROM; aligned with char_code.
- hcount_out, vcount_out  out  11  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing.
- rgb_out  out  12  composed colour.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - On reset every pipeline register and every output is 0: char_yx=0, char_line=0, rgb_out=0, all sync/blank/count outputs 0.
- Glyph size is fixed at 16x16 px. The text area is TEXT_COLS*16 by TEXT_ROWS*16 px.
- Region decode:
  - rel_x = hcount_in - X_POS; rel_y = vcount_in - Y_POS.
  - in_region = (hcount_in >= X_POS) && (hcount_in < X_POS+TEXT_COLS*16) && (vcount_in >= Y_POS) && (vcount_in < Y_POS+TEXT_ROWS*16).
  - Comparisons are unsigned 11-bit, with no wrap: a pixel left of or above the area is never in-region.
- Pipeline (cycle 0 = inputs sampled):
  - S1 (edge 1): char_yx <= in_region ? {rel_y[8:4], rel_x[8:4]} : 10'h000. Also register line = rel_y[3:0], col = rel_x[3:0], in_region, timing, counters and rgb.
  - S2 (edge 2): the character ROM presents char_code. char_line is driven from the S2 copy of line, so the font address is aligned.
  - S3 (edge 3): the font ROM presents font_row. The S3 copies of col, in_region, timing and rgb are held.
  - S4 (edge 4): compose the outputs:
    - pix = font_row[15 - col_s3].
    - rgb_out <= (hblnk_s3 || vblnk_s3) ? 12'h000 : (in_region_s3 && pix) ? FG_COLOR : rgb_s3.
    - All timing and count outputs <= their S3 copies.
- Latency: fixed 4 clk from every input to every output. There is no stall or back-pressure; the block accepts one pixel per clk.
- Outside the region, char_yx = 0 (ROM returns a space) and rgb passes through unchanged.
- Glyph code 0 must render blank. The font ROM guarantees this; the block does not special-case it.
- Line-boundary wrap: when hcount wraps to 0, the pipeline drains naturally. There is no cross-line state.
- Reset mid-frame: the pipeline restarts. The first 4 clk after release output reset values, then the outputs track normally.

Decomposition:
- Package vga_text_pkg holds:
  - GLYPH_W=16, GLYPH_H=16.
  - CHAR_CODE_W=7, CHAR_YX_W=10.
  - RGB_W=12.
  - a VGA timing bundle typedef {hcount, vcount, hsync, vsync, hblnk, vblnk}.
- One sub-module is natural: vga_timing_delay, a parameterised N-stage delay line for the timing bundle plus rgb. It is instantiated with N=3, followed by the S4 register.
- The ROMs are external; the bench instantiates the real character ROM and a font ROM model.

Test Plan:
- Reset: assert rst_n=0 mid-line -> all outputs 0 immediately (asynchronous); after release, outputs equal the inputs delayed by exactly 4 clk.
- Out-of-region: hcount=100, vcount=30, rgb_in=12'h0A5 -> char_yx=0, rgb_out=12'h0A5 after 4 clk, hsync_out = hsync_in delayed 4.
- Addressing: hcount=X_POS+16*3+5, vcount=Y_POS+16*2+7 -> char_yx=10'h043 at edge 1; char_line=7 at edge 2, coincident with char_code 117 ('u').
- Glyph overlay: font_row=16'h8001 for the in-region pixel at col 0 -> rgb_out=FG_COLOR; col 1 -> rgb_in; col 15 -> FG_COLOR; each 4 clk after input.
- Boundaries: hcount=X_POS+511 is in-region (char_x=31); X_POS+512 is out. vcount=Y_POS-1 is out; Y_POS+319 is in (char_y=19); Y_POS+320 is out.
- Blanking: in-region, pix=1, hblnk_in=1 -> rgb_out=12'h000, hblnk_out=1 after 4 clk.
